// File: rtl/calc_pkg.sv
// Shared types and segment constants for the calculator display controller.
package calc_pkg;

    typedef enum logic [1:0] {
        ST_ERRO       = 2'b00,
        ST_OCUPADO    = 2'b01,
        ST_PRONTO     = 2'b10,
        ST_IMPRIMINDO = 2'b11
    } status_t;

    localparam int N_DIGITS = 8;

    // Active-low, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low seven-segment decoder; codes 10..15 or blank_i give a dark digit.
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank_i,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank_i && digit <= 4'd9)
            seg = SEG_TABLE[digit];
    end

endmodule

// File: rtl/calc_display_ctrl.sv
// Captures the core's digit stream into an 8-digit buffer and scans it onto
// 8 common-anode displays. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module calc_display_ctrl
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 50_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] status,
    input  logic [3:0] data,
    input  logic [3:0] pos,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [3:0]       digit_buf [N_DIGITS];
    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       scan_idx;
    status_t          status_q;

    logic [3:0] cur_digit;
    logic       lz_blank;
    logic [6:0] dec_seg;
    logic [7:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    // Capture stage: erro and imprimindo both carry digits, pos 8..15 is dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_DIGITS; i++)
                digit_buf[i] <= 4'hF;
        end else if ((status == ST_ERRO || status == ST_IMPRIMINDO) && !pos[3]) begin
            digit_buf[pos[2:0]] <= data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            scan_idx <= '0;
            status_q <= ST_PRONTO;
        end else begin
            status_q <= status_t'(status);
            if (div_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                div_cnt  <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign cur_digit = digit_buf[scan_idx];

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // A zero is leading when nothing above it holds a nonzero digit
    always_comb begin
        upper_zero = 1'b1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j > int'(scan_idx) && digit_buf[j] inside {[4'd1:4'd9]})
                upper_zero = 1'b0;
        end
        lz_blank = (scan_idx != 3'd0) && (cur_digit == 4'd0) && upper_zero;
    end
`else
    assign lz_blank = 1'b0;
`endif

    seg7_decoder u_dec (
        .digit   (cur_digit),
        .blank_i (lz_blank),
        .seg     (dec_seg)
    );

    always_comb begin
        an_next  = ~(8'b1 << scan_idx);
        seg_next = dec_seg;
        dp_next  = 1'b1;
        case (status_q)
            ST_ERRO: begin
                if (scan_idx == 3'd2)
                    seg_next = SEG_E;
                else if (scan_idx < 3'd2)
                    seg_next = SEG_R;
                else
                    seg_next = SEG_BLANK;
            end
            ST_OCUPADO: dp_next = (scan_idx != 3'd7);
            default:    dp_next = 1'b1;
        endcase
    end

    // Output stage: one cycle behind scan_idx
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an  <= 8'hFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Self-checking bench for calc_display_ctrl with REFRESH_DIV=4; the reference
// model predicts each displayed digit from a digit array and the elapsed cycle count.
module tb_calc_display_ctrl;

    localparam int RD = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int         n_pass  = 0;
    int         n_total = 0;
    int         ncyc;
    logic [3:0] mbuf [8];
    logic [1:0] cur_st;

    calc_display_ctrl #(.REFRESH_DIV(RD)) dut (
        .clock  (clock),
        .reset  (reset),
        .status (status),
        .data   (data),
        .pos    (pos),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    always #5 clock = ~clock;

    // Clock edges seen since reset was released
    always @(posedge clock or negedge reset) begin
        if (!reset) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    // Output after edge n shows digit ((n-1)/RD) mod 8
    function automatic int cur_idx();
        return ((ncyc - 1) / RD) % 8;
    endfunction

    function automatic logic [6:0] digit_pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        if (cur_st == 2'b00) begin
            if (idx == 2) return 7'h06;
            if (idx < 2)  return 7'h2F;
            return 7'h7F;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && mbuf[idx] == 4'd0) begin
            bit all_zero = 1'b1;
            for (int j = idx; j < 8; j++)
                if (mbuf[j] >= 4'd1 && mbuf[j] <= 4'd9) all_zero = 1'b0;
            if (all_zero) return 7'h7F;
        end
`endif
        return digit_pat(mbuf[idx]);
    endfunction

    function automatic logic exp_dp(input int idx);
        return !(cur_st == 2'b01 && idx == 7);
    endfunction

    function automatic logic [7:0] exp_an(input int idx);
        return ~(8'b1 << idx);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mbuf[i] = 4'hF;
    endtask

    task automatic drive(input logic [1:0] s, input logic [3:0] p, input logic [3:0] d);
        @(negedge clock);
        status = s;
        pos    = p;
        data   = d;
        cur_st = s;
        if ((s == 2'b00 || s == 2'b11) && p < 4'd8) mbuf[p[2:0]] = d;
    endtask

    task automatic settle(input logic [1:0] s);
        drive(s, 4'd15, 4'd0);
        @(posedge clock);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #3 reset = 1'b0;
        clear_model();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        status = 2'b10; pos = 4'd15; data = 4'd0; cur_st = 2'b10;
        reset = 1'b1;
        #2 reset = 1'b0;
        clear_model();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (13) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        n_total++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1)
            $display("FAIL reset_async: an=%h seg=%h dp=%b, expected an=ff seg=7f dp=1", an, seg, dp);
        else n_pass++;
        @(posedge clock); #1;
        n_total++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1)
            $display("FAIL reset_held: an=%h seg=%h dp=%b, expected an=ff seg=7f dp=1", an, seg, dp);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        n_total++;
        if (an !== 8'hFE)
            $display("FAIL reset_first_anode: an=%h, expected an=fe", an);
        else n_pass++;
        for (int c = 0; c < 32; c++) begin
            int i;
            @(posedge clock); #1;
            i = cur_idx();
            n_total++;
            if (an !== exp_an(i) || seg !== exp_seg(i) || dp !== exp_dp(i))
                $display("FAIL reset_blank idx%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, an, seg, dp, exp_an(i), exp_seg(i), exp_dp(i));
            else n_pass++;
        end
    endtask

    task automatic test_capture();
        drive(2'b11, 4'd0, 4'd3);
        drive(2'b11, 4'd1, 4'd2);
        drive(2'b11, 4'd2, 4'd1);
        drive(2'b11, 4'd3, 4'd0);
        settle(2'b10);
        for (int c = 0; c < 32; c++) begin
            int i;
            @(posedge clock); #1;
            i = cur_idx();
            n_total++;
            if (an !== exp_an(i) || seg !== exp_seg(i) || dp !== exp_dp(i))
                $display("FAIL capture idx%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, an, seg, dp, exp_an(i), exp_seg(i), exp_dp(i));
            else n_pass++;
        end
    endtask

    task automatic test_hold();
        repeat (8) drive(2'b10, 4'd0, 4'd9);
        repeat (4) drive(2'b01, 4'd1, 4'd8);
        settle(2'b10);
        for (int c = 0; c < 32; c++) begin
            int i;
            @(posedge clock); #1;
            i = cur_idx();
            n_total++;
            if (an !== exp_an(i) || seg !== exp_seg(i) || dp !== exp_dp(i))
                $display("FAIL hold idx%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, an, seg, dp, exp_an(i), exp_seg(i), exp_dp(i));
            else n_pass++;
        end
    endtask

    task automatic test_err();
        repeat (3) drive(2'b00, 4'd5, 4'd7);
        settle(2'b00);
        for (int c = 0; c < 32; c++) begin
            int i;
            @(posedge clock); #1;
            i = cur_idx();
            n_total++;
            if (an !== exp_an(i) || seg !== exp_seg(i) || dp !== exp_dp(i))
                $display("FAIL err idx%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, an, seg, dp, exp_an(i), exp_seg(i), exp_dp(i));
            else n_pass++;
        end
        settle(2'b10);
        for (int c = 0; c < 32; c++) begin
            int i;
            @(posedge clock); #1;
            i = cur_idx();
            n_total++;
            if (an !== exp_an(i) || seg !== exp_seg(i) || dp !== exp_dp(i))
                $display("FAIL err_capture idx%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, an, seg, dp, exp_an(i), exp_seg(i), exp_dp(i));
            else n_pass++;
        end
        drive(2'b11, 4'd15, 4'd0);
        pulse_reset();
        for (int c = 0; c < 32; c++) begin
            int i;
            @(posedge clock); #1;
            i = cur_idx();
            n_total++;
            if (an !== exp_an(i) || seg !== exp_seg(i) || dp !== exp_dp(i))
                $display("FAIL err_reset_blank idx%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, an, seg, dp, exp_an(i), exp_seg(i), exp_dp(i));
            else n_pass++;
        end
    endtask

    task automatic test_busy();
        for (int p = 0; p < 8; p++)
            drive(2'b11, 4'(p), 4'($urandom_range(0, 15)));
        settle(2'b01);
        for (int c = 0; c < 32; c++) begin
            int i;
            @(posedge clock); #1;
            i = cur_idx();
            n_total++;
            if (an !== exp_an(i) || seg !== exp_seg(i) || dp !== exp_dp(i))
                $display("FAIL busy idx%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, an, seg, dp, exp_an(i), exp_seg(i), exp_dp(i));
            else n_pass++;
        end
    endtask

    task automatic test_ignore_pos();
        drive(2'b11, 4'd1, 4'd8);
        repeat (4) drive(2'b11, 4'd9, 4'd5);
        repeat (2) drive(2'b00, 4'd14, 4'd6);
        settle(2'b10);
        for (int c = 0; c < 33; c++) begin
            int i;
            @(posedge clock); #1;
            i = cur_idx();
            n_total++;
            if (an !== exp_an(i) || seg !== exp_seg(i) || dp !== exp_dp(i))
                $display("FAIL ignore_pos idx%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                         i, an, seg, dp, exp_an(i), exp_seg(i), exp_dp(i));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 12; k++) begin
                logic [1:0] s;
                logic [3:0] d;
                s = 2'($urandom_range(0, 3));
                d = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                drive(s, 4'($urandom_range(0, 15)), d);
            end
            settle(2'($urandom_range(0, 3)));
            for (int c = 0; c < 32; c++) begin
                int i;
                @(posedge clock); #1;
                i = cur_idx();
                n_total++;
                if (an !== exp_an(i) || seg !== exp_seg(i) || dp !== exp_dp(i))
                    $display("FAIL random r%0d idx%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                             r, i, an, seg, dp, exp_an(i), exp_seg(i), exp_dp(i));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_hold();
        test_err();
        test_busy();
        test_ignore_pos();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
